// File: rtl/phys_reg_allocator_pkg.sv
// Shared frontend defines used by the physical register allocator.
// Address width and register count track the rename/frontend configuration.
package phys_reg_allocator_pkg;

   localparam int FE_PR_ADDR_W = 6;
   localparam int FE_PHYS_REGS = 64;
   localparam int FE_FETCH_WIDTH = 4;
   localparam int FE_CMPL_WIDTH = 6;

endpackage

// File: rtl/phys_reg_allocator_if.sv
// Allocation / free bundle between the renamer, retire and the allocator.
// Master is the renamer/retire side, slave is the allocator.
interface phys_reg_allocator_if
   import phys_reg_allocator_pkg::*;
#(
   parameter int PR_ADDR_W = FE_PR_ADDR_W,
   parameter int ALLOC_WIDTH = FE_FETCH_WIDTH,
   parameter int FREE_WIDTH = FE_CMPL_WIDTH
);

   logic [2:0] alloc_count;
   logic alloc_valid;
   logic alloc_ready;
   logic [ALLOC_WIDTH*PR_ADDR_W-1:0] alloc_regs;
   logic [FREE_WIDTH*PR_ADDR_W-1:0] free_regs;
   logic [FREE_WIDTH-1:0] free_valid;
   logic [PR_ADDR_W:0] free_count;
   logic alloc_err;

   modport master (
      output alloc_count, alloc_valid, free_regs, free_valid,
      input alloc_ready, alloc_regs, free_count, alloc_err
   );

   modport slave (
      input alloc_count, alloc_valid, free_regs, free_valid,
      output alloc_ready, alloc_regs, free_count, alloc_err
   );

endinterface

// File: rtl/phys_reg_allocator_free_pick.sv
// Combinational picker: indices of the N lowest set bits of a vector.
// Slots beyond the population of set bits read as 0.
module free_pick #(
   parameter int WIDTH = 64,
   parameter int N = 4,
   parameter int IDX_W = 6
) (
   input logic [WIDTH-1:0] bits,
   output logic [N*IDX_W-1:0] picks
);

   int cnt;

   always_comb begin
      picks = '0;
      cnt = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bits[i]) begin
            for (int k = 0; k < N; k++) begin
               if (cnt == k) picks[k*IDX_W +: IDX_W] = IDX_W'(i);
            end
            cnt = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/phys_reg_allocator.sv
// Free-list allocator for physical registers: bitmap plus running count,
// up to ALLOC_WIDTH grants and FREE_WIDTH returns per cycle.
module phys_reg_allocator
   import phys_reg_allocator_pkg::*;
#(
   parameter int PR_ADDR_W = FE_PR_ADDR_W,
   parameter int PHYS_REGS = FE_PHYS_REGS,
   parameter int ARCH_REGS = 8,
   parameter int ALLOC_WIDTH = FE_FETCH_WIDTH,
   parameter int FREE_WIDTH = FE_CMPL_WIDTH
) (
   input logic clk,
   input logic rst,
   phys_reg_allocator_if.slave bus
);

   localparam int CNT_W = PR_ADDR_W + 1;
   localparam logic [PHYS_REGS-1:0] RST_MAP =
      {PHYS_REGS{1'b1}} << (ARCH_REGS + 2);
   localparam logic [CNT_W-1:0] RST_CNT =
      CNT_W'(PHYS_REGS - 2 - ARCH_REGS);

   logic [PHYS_REGS-1:0] bitmap;
   logic [PHYS_REGS-1:0] bitmap_nx;
   logic [PHYS_REGS-1:0] cons_mask;
   logic [PHYS_REGS-1:0] free_mask;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_nx;
   logic [CNT_W-1:0] free_add;
   logic [ALLOC_WIDTH*PR_ADDR_W-1:0] picks;
   logic [PR_ADDR_W-1:0] r;
   logic over;
   logic ready;
   logic fire;
   logic dup;
   logic err;

   free_pick #(
      .WIDTH(PHYS_REGS),
      .N(ALLOC_WIDTH),
      .IDX_W(PR_ADDR_W)
   ) u_pick (
      .bits(bitmap),
      .picks(picks)
   );

   always_comb begin
      over = bus.alloc_count > 3'(ALLOC_WIDTH);
      ready = !over && (CNT_W'(bus.alloc_count) <= count_q);
      fire = bus.alloc_valid && ready;
      cons_mask = '0;
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
         if (fire && (3'(k) < bus.alloc_count))
            cons_mask[picks[k*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
      end
   end

   // A register granted this cycle may come straight back: free wins, no error.
   always_comb begin
      free_mask = '0;
      free_add = '0;
      dup = 1'b0;
      r = '0;
      for (int j = 0; j < FREE_WIDTH; j++) begin
         r = bus.free_regs[j*PR_ADDR_W +: PR_ADDR_W];
         if (bus.free_valid[j] && (r > PR_ADDR_W'(1))) begin
            if (free_mask[r] || (bitmap[r] && !cons_mask[r])) begin
               dup = 1'b1;
            end else begin
               free_mask[r] = 1'b1;
               free_add = free_add + CNT_W'(1);
            end
         end
      end
      bitmap_nx = (bitmap & ~cons_mask) | free_mask;
      count_nx = count_q
               - (fire ? CNT_W'(bus.alloc_count) : CNT_W'(0))
               + free_add;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bitmap <= RST_MAP;
         count_q <= RST_CNT;
         err <= 1'b0;
      end else begin
         bitmap <= bitmap_nx;
         count_q <= count_nx;
         err <= err | (bus.alloc_valid && over) | dup;
      end
   end

   assign bus.alloc_ready = ready;
   assign bus.alloc_regs = picks;
   assign bus.free_count = count_q;
   assign bus.alloc_err = err;

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Directed bench for phys_reg_allocator with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs sampled after settling.
module tb_phys_reg_allocator;

   logic clk;
   logic rst;
   int tests;
   int fails;

   phys_reg_allocator_if bus ();

   phys_reg_allocator dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] slot(int k);
      return 32'(bus.alloc_regs[k*6 +: 6]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.alloc_valid = 1'b0;
      bus.alloc_count = 3'd0;
      bus.free_valid = '0;
      bus.free_regs = '0;
   endtask

   task automatic set_free(int k, int reg_idx);
      bus.free_regs[k*6 +: 6] = 6'(reg_idx);
      bus.free_valid[k] = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_count", 32'(bus.free_count), 54);
      chk("rst_err", 32'(bus.alloc_err), 0);
      chk("rst_s0", slot(0), 10);
      chk("rst_s3", slot(3), 13);

      bus.alloc_count = 3'd4;
      bus.alloc_valid = 1'b1;
      #1;
      chk("a4_ready", 32'(bus.alloc_ready), 1);
      chk("a4_s1", slot(1), 11);
      chk("a4_s2", slot(2), 12);
      tick();
      idle();
      #1;
      chk("a4_count", 32'(bus.free_count), 50);
      chk("a4_next_s0", slot(0), 14);
      chk("a4_next_s3", slot(3), 17);

      bus.alloc_count = 3'd4;
      bus.alloc_valid = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      idle();
      #1;
      chk("drain_count", 32'(bus.free_count), 2);
      chk("drain_s0", slot(0), 62);
      chk("drain_s1", slot(1), 63);
      chk("drain_s2", slot(2), 0);

      bus.alloc_count = 3'd3;
      bus.alloc_valid = 1'b1;
      #1;
      chk("req3_ready", 32'(bus.alloc_ready), 0);
      tick();
      chk("req3_count", 32'(bus.free_count), 2);
      chk("req3_s0", slot(0), 62);
      bus.alloc_count = 3'd2;
      #1;
      chk("req2_ready", 32'(bus.alloc_ready), 1);
      tick();
      idle();
      #1;
      chk("empty_count", 32'(bus.free_count), 0);
      chk("empty_s0", slot(0), 0);
      bus.alloc_count = 3'd1;
      #1;
      chk("empty_ready1", 32'(bus.alloc_ready), 0);
      bus.alloc_count = 3'd0;
      bus.alloc_valid = 1'b1;
      #1;
      chk("empty_ready0", 32'(bus.alloc_ready), 1);

      set_free(0, 12);
      tick();
      idle();
      #1;
      chk("reuse_s0", slot(0), 12);
      chk("reuse_count", 32'(bus.free_count), 1);

      set_free(0, 13);
      tick();
      idle();
      #1;
      chk("f13_count", 32'(bus.free_count), 2);

      bus.alloc_count = 3'd2;
      bus.alloc_valid = 1'b1;
      set_free(0, 30);
      set_free(1, 31);
      set_free(2, 1);
      tick();
      idle();
      #1;
      chk("mix_count", 32'(bus.free_count), 2);
      chk("mix_err", 32'(bus.alloc_err), 0);
      chk("mix_s0", slot(0), 30);
      chk("mix_s1", slot(1), 31);

      bus.alloc_count = 3'd1;
      bus.alloc_valid = 1'b1;
      set_free(0, 30);
      tick();
      idle();
      #1;
      chk("cf_count", 32'(bus.free_count), 2);
      chk("cf_err", 32'(bus.alloc_err), 0);
      chk("cf_s0", slot(0), 30);

      set_free(0, 20);
      set_free(1, 20);
      tick();
      idle();
      #1;
      chk("dup_count", 32'(bus.free_count), 3);
      chk("dup_err", 32'(bus.alloc_err), 1);
      chk("dup_s0", slot(0), 20);
      set_free(0, 20);
      tick();
      idle();
      #1;
      chk("dup2_count", 32'(bus.free_count), 3);
      tick();
      tick();
      chk("err_sticky", 32'(bus.alloc_err), 1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst2_err", 32'(bus.alloc_err), 0);
      bus.alloc_count = 3'd5;
      bus.alloc_valid = 1'b1;
      #1;
      chk("a5_ready", 32'(bus.alloc_ready), 0);
      tick();
      idle();
      #1;
      chk("a5_err", 32'(bus.alloc_err), 1);
      chk("a5_count", 32'(bus.free_count), 54);

      rst = 1'b1;
      bus.alloc_count = 3'd4;
      bus.alloc_valid = 1'b1;
      set_free(0, 5);
      tick();
      rst = 1'b0;
      idle();
      #1;
      chk("rst3_count", 32'(bus.free_count), 54);
      chk("rst3_err", 32'(bus.alloc_err), 0);
      chk("rst3_s0", slot(0), 10);
      chk("rst3_s3", slot(3), 13);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
